pulse_pacer: RTL

Rate-shaping stage in the clk1 domain, directly upstream of the toggle-flop pulse synchronizer. It accepts single-cycle event pulses at any rate. It re-emits them as single-cycle pulses spaced at least GAP clk1 cycles apart, so every pulse survives the crossing into clk2. Events that arrive too fast are queued in a saturating pending counter; events beyond its capacity are dropped and flagged.

---
 rtl/pulse_pacer_pkg.sv | 20 ++
 rtl/pulse_pacer_gap_cnt.sv | 28 ++
 rtl/pulse_pacer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pulse_pacer_pkg.sv
// Shared types and elaboration helpers for the pulse_pacer rate-shaping stage.
package pulse_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // Gap counter holds GAP-2 at most, so $clog2(GAP) bits always suffice.
  function automatic int unsigned gap_cnt_w(input int unsigned gap);
    return (gap < 2) ? 1 : $clog2(gap);
  endfunction

  function automatic bit params_legal(input int unsigned cnt_w, input int unsigned gap);
    return (cnt_w >= 1) && (gap >= 2);
  endfunction

endpackage

// File: rtl/pulse_pacer_gap_cnt.sv
// Loadable down-counter timing the quiet interval between paced pulses.
module pulse_pacer_gap_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk1,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Saturates at zero; load has priority over decrement.
  always_ff @(posedge clk1) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/pulse_pacer.sv
// Paces event pulses at least GAP clk1 cycles apart ahead of the pulse synchronizer.
// Optional return-path handshake enabled by defining PULSE_PACER_ACK_EN.
module pulse_pacer
  import pulse_pacer_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 6
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             event_in,
  input  logic             clr_ovf,
`ifdef PULSE_PACER_ACK_EN
  input  logic             ack_in,
`endif
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned        GCW      = gap_cnt_w(GAP);
  localparam logic [GCW-1:0]     GAP_LOAD = GCW'(GAP - 2);
  localparam logic [CNT_W-1:0]   PEND_MAX = '1;

  if (!params_legal(CNT_W, GAP)) begin : g_param_check
    $error("pulse_pacer: illegal parameters CNT_W=%0d GAP=%0d", CNT_W, GAP);
  end

  state_e           state;
  state_e           state_nxt;
  logic             gap_load;
  logic             gap_en;
  logic             gap_zero_c;
  logic             inc;
  logic             dec;
  logic             drop;
  logic             ack_ready;
  logic [CNT_W-1:0] pending_nxt;
  logic             overflow_nxt;
  logic             busy_nxt;

`ifdef PULSE_PACER_ACK_EN
  logic ack_seen;
  logic ack_seen_nxt;

  // A fresh pulse re-arms the handshake; acks outside a transfer are ignored.
  always_comb begin
    ack_seen_nxt = ack_seen;
    if (state_nxt == ST_PULSE) begin
      ack_seen_nxt = 1'b0;
    end else if (ack_in && (state != ST_IDLE)) begin
      ack_seen_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      ack_seen <= 1'b0;
    end else begin
      ack_seen <= ack_seen_nxt;
    end
  end

  assign ack_ready = ack_seen;
`else
  assign ack_ready = 1'b1;
`endif

  pulse_pacer_gap_cnt #(
    .W (GCW)
  ) u_gap_cnt (
    .clk1     (clk1),
    .reset    (reset),
    .load     (gap_load),
    .en       (gap_en),
    .load_val (GAP_LOAD),
    .zero_c   (gap_zero_c)
  );

  // Next state; dec marks a pulse drawn from the backlog rather than a direct event.
  always_comb begin
    state_nxt = state;
    gap_load  = 1'b0;
    gap_en    = 1'b0;
    dec       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (event_in) begin
          state_nxt = ST_PULSE;
        end else if (pending != '0) begin
          state_nxt = ST_PULSE;
          dec       = 1'b1;
        end
      end
      ST_PULSE: begin
        state_nxt = ST_GAP;
        gap_load  = 1'b1;
      end
      ST_GAP: begin
        gap_en = 1'b1;
        if (gap_zero_c) begin
          if (!ack_ready) begin
            state_nxt = ST_ACK;
          end else if (pending != '0) begin
            state_nxt = ST_PULSE;
            dec       = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_ACK: begin
        if (ack_ready) begin
          if (pending != '0) begin
            state_nxt = ST_PULSE;
            dec       = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Backlog bookkeeping: a direct event in IDLE never touches the counter.
  always_comb begin
    inc          = event_in && (state != ST_IDLE);
    drop         = inc && !dec && (pending == PEND_MAX);
    pending_nxt  = pending;
    if (inc && !dec && !drop) begin
      pending_nxt = pending + CNT_W'(1);
    end else if (dec && !inc) begin
      pending_nxt = pending - CNT_W'(1);
    end
    overflow_nxt = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow);
    busy_nxt     = (state_nxt != ST_IDLE) || (pending_nxt != '0);
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state     <= ST_IDLE;
      pulse_out <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_out <= (state_nxt == ST_PULSE);
      pending   <= pending_nxt;
      overflow  <= overflow_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
